// File: rtl/calculator.sv
// calculator: integer four-function calculator at board top level.
// Keys feed a left-to-right accumulator; the result or current entry is shown
// on an HD44780 character LCD (line 1, right-aligned decimal), a 7-segment
// digit and status LEDs.
// Build option: define DEBOUNCE_EN to require DEB_CYCLES stable cycles per
// button before its edge is recognised.
//
// LCD sequencer states:
//   state   | meaning
//   L_PREP  | choose next byte (init command, refresh start, or line character)
//   L_CONV  | binary-to-BCD conversion of the displayed value before a refresh
//   L_SETUP | rs/data driven, lcd_e low (setup time)
//   L_PULSE | lcd_e high
//   L_HOLD  | lcd_e low, rs/data held
//   L_WAIT  | idle gap after the write
module calculator #(
    parameter int LCD_E_CYCLES    = 50,
    parameter int LCD_WAIT_CYCLES = 2000,
    parameter int DEB_CYCLES      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       swp0,
    input  logic       swp1,
    input  logic       swp2,
    input  logic       swp3,
    input  logic       swp4,
    input  logic       swp5,
    input  logic       swp6,
    input  logic       swp7,
    input  logic       swp8,
    input  logic       swp9,
    input  logic       lrd,
    input  logic       swd1,
    input  logic       swd2,
    input  logic       swd3,
    input  logic       swd4,
    input  logic       swd5,
    input  logic       swd6,
    input  logic       swd7,
    input  logic       swd8,
    output logic [7:0] seg,
    output logic [7:0] led,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    localparam int NK = 19;
    localparam int TW = 24;

    // Key index doubles as priority: lower index wins on simultaneous edges.
    localparam logic [4:0] K_AC   = 5'd0;
    localparam logic [4:0] K_CE   = 5'd1;
    localparam logic [4:0] K_EQ   = 5'd2;
    localparam logic [4:0] K_ADD  = 5'd3;
    localparam logic [4:0] K_SUB  = 5'd4;
    localparam logic [4:0] K_MUL  = 5'd5;
    localparam logic [4:0] K_DIV  = 5'd6;
    localparam logic [4:0] K_SIGN = 5'd7;
    localparam logic [4:0] K_BS   = 5'd8;
    localparam logic [4:0] K_D0   = 5'd9;

    typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;
    typedef enum logic [2:0] {L_PREP, L_CONV, L_SETUP, L_PULSE, L_HOLD, L_WAIT} lcd_state_t;

    logic [NK-1:0] key_raw, sync1, sync2, key_stable, key_prev, key_rise;
    logic          key_hit;
    logic [4:0]    key_idx;
    op_t           key_op;

    logic signed [31:0] acc, operand, apply_res, disp_val;
    logic [31:0]        entry;
    logic [3:0]         ndig, digit;
    logic               sign, entry_active, err, fresh, div_zero;
    op_t                op;
    logic [6:0]         seg_code, seg_digit;

    assign key_raw = {swp9, swp8, swp7, swp6, swp5, swp4, swp3, swp2, swp1, swp0,
                      swd6, swd1, swd5, swd4, swd3, swd2, swd8, lrd, swd7};

    // Two-flop synchroniser for all buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] deb_cnt [NK];

    // Accept a new button level only after it has differed for DEB_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_stable <= '0;
            for (int i = 0; i < NK; i++) deb_cnt[i] <= DW'(DEB_CYCLES - 1);
        end else begin
            for (int i = 0; i < NK; i++) begin
                if (sync2[i] == key_stable[i]) begin
                    deb_cnt[i] <= DW'(DEB_CYCLES - 1);
                end else if (deb_cnt[i] == '0) begin
                    key_stable[i] <= sync2[i];
                    deb_cnt[i]    <= DW'(DEB_CYCLES - 1);
                end else begin
                    deb_cnt[i] <= deb_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    assign key_stable = sync2;
`endif

    // Previous level for rising-edge detection: one action per press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_prev <= '0;
        else      key_prev <= key_stable;
    end

    assign key_rise = key_stable & ~key_prev;

    // Pick the lowest-index rising key.
    always_comb begin
        key_hit = 1'b0;
        key_idx = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (key_rise[i]) begin
                key_hit = 1'b1;
                key_idx = 5'(i);
            end
        end
    end

    // Map operator keys to the op they leave pending; equals leaves none.
    always_comb begin
        key_op = OP_NONE;
        case (key_idx)
            K_ADD:   key_op = OP_ADD;
            K_SUB:   key_op = OP_SUB;
            K_MUL:   key_op = OP_MUL;
            K_DIV:   key_op = OP_DIV;
            default: key_op = OP_NONE;
        endcase
    end

    assign digit   = 4'(key_idx - K_D0);
    assign operand = sign ? (32'sd0 - $signed(entry)) : $signed(entry);

    // Digit to segment pattern (a..g in bits 0..6).
    always_comb begin
        seg_digit = 7'h3F;
        case (digit)
            4'd0:    seg_digit = 7'h3F;
            4'd1:    seg_digit = 7'h06;
            4'd2:    seg_digit = 7'h5B;
            4'd3:    seg_digit = 7'h4F;
            4'd4:    seg_digit = 7'h66;
            4'd5:    seg_digit = 7'h6D;
            4'd6:    seg_digit = 7'h7D;
            4'd7:    seg_digit = 7'h07;
            4'd8:    seg_digit = 7'h7F;
            4'd9:    seg_digit = 7'h6F;
            default: seg_digit = 7'h3F;
        endcase
    end

    // Result of applying the pending op to acc and the current operand.
    // MIN / -1 is handled as negation so it wraps instead of trapping.
    always_comb begin
        div_zero  = 1'b0;
        apply_res = acc;
        case (op)
            OP_NONE: apply_res = operand;
            OP_ADD:  apply_res = acc + operand;
            OP_SUB:  apply_res = acc - operand;
            OP_MUL:  apply_res = acc * operand;
            OP_DIV: begin
                if (operand == 32'sd0)               div_zero  = 1'b1;
                else if (operand == -32'sd1)         apply_res = 32'sd0 - acc;
                else                                 apply_res = acc / operand;
            end
            default: apply_res = acc;
        endcase
    end

    // Calculator state: one key action per cycle; only all-clear works in error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc          <= '0;
            entry        <= '0;
            ndig         <= '0;
            sign         <= 1'b0;
            entry_active <= 1'b0;
            op           <= OP_NONE;
            err          <= 1'b0;
            fresh        <= 1'b0;
            seg_code     <= 7'h3F;
        end else if (key_hit && (!err || key_idx == K_AC)) begin
            case (key_idx)
                K_AC: begin
                    acc          <= '0;
                    entry        <= '0;
                    ndig         <= '0;
                    sign         <= 1'b0;
                    entry_active <= 1'b0;
                    op           <= OP_NONE;
                    err          <= 1'b0;
                    fresh        <= 1'b0;
                    seg_code     <= 7'h3F;
                end
                K_CE: begin
                    entry        <= '0;
                    ndig         <= '0;
                    sign         <= 1'b0;
                    entry_active <= 1'b0;
                end
                K_EQ, K_ADD, K_SUB, K_MUL, K_DIV: begin
                    if (entry_active) begin
                        if (div_zero) err <= 1'b1;
                        else          acc <= apply_res;
                        entry        <= '0;
                        ndig         <= '0;
                        sign         <= 1'b0;
                        entry_active <= 1'b0;
                    end
                    op    <= (entry_active && div_zero) ? OP_NONE : key_op;
                    fresh <= (key_idx == K_EQ);
                end
                K_SIGN: sign <= ~sign;
                K_BS: begin
                    entry <= entry / 32'd10;
                    if (ndig != 4'd0) ndig <= ndig - 4'd1;
                end
                default: begin
                    seg_code <= seg_digit;
                    if (fresh) begin
                        acc   <= '0;
                        op    <= OP_NONE;
                        fresh <= 1'b0;
                    end
                    if (ndig < 4'd9) begin
                        entry        <= entry * 32'd10 + {28'd0, digit};
                        ndig         <= ndig + 4'd1;
                        entry_active <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign disp_val = entry_active ? operand : acc;
    assign seg      = {sign, seg_code};
    assign led      = {disp_val[31] & ~err, err, entry_active, 1'b0,
                       op == OP_DIV, op == OP_MUL, op == OP_SUB, op == OP_ADD};
    assign lcd_rw   = 1'b0;

    // ---------------- LCD side ----------------
    lcd_state_t     lcd_state, lcd_next;
    logic [TW-1:0]  tmr;
    logic           tmr_tc, init_phase, conv_start, conv_done, load_byte;
    logic [4:0]     step;
    logic [31:0]    conv_bin;
    logic [39:0]    conv_bcd, bcd_adj;
    logic [5:0]     conv_cnt;
    logic           show_neg, show_err;
    logic [3:0]     ndisp, char_pos, k, digit_at;
    logic [7:0]     ch, wr_byte;
    logic           wr_rs;

    assign tmr_tc     = (tmr == '0);
    assign conv_start = (lcd_state == L_PREP) && !init_phase && (step == 5'd0);
    assign conv_done  = (conv_cnt == 6'd0);
    assign load_byte  = (lcd_next == L_SETUP) && (lcd_state != L_SETUP);

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lcd_state <= L_PREP;
        else      lcd_state <= lcd_next;
    end

    // Sequencer next state.
    always_comb begin
        lcd_next = lcd_state;
        case (lcd_state)
            L_PREP:  lcd_next = (init_phase || step != 5'd0) ? L_SETUP : L_CONV;
            L_CONV:  if (conv_done) lcd_next = L_SETUP;
            L_SETUP: if (tmr_tc) lcd_next = L_PULSE;
            L_PULSE: if (tmr_tc) lcd_next = L_HOLD;
            L_HOLD:  if (tmr_tc) lcd_next = L_WAIT;
            L_WAIT:  if (tmr_tc) lcd_next = L_PREP;
            default: lcd_next = L_PREP;
        endcase
    end

    // Down-counter reloaded on every state change; terminal count ends the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (lcd_next != lcd_state) begin
            case (lcd_next)
                L_SETUP, L_PULSE, L_HOLD: tmr <= TW'(LCD_E_CYCLES - 1);
                L_WAIT:                   tmr <= TW'(LCD_WAIT_CYCLES - 1);
                default:                  tmr <= '0;
            endcase
        end else if (!tmr_tc) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Step through 4 init commands once, then 0x80 + 16 characters forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step       <= '0;
            init_phase <= 1'b1;
        end else if (lcd_state == L_WAIT && tmr_tc) begin
            if (init_phase) begin
                if (step == 5'd3) begin
                    init_phase <= 1'b0;
                    step       <= '0;
                end else begin
                    step <= step + 5'd1;
                end
            end else if (step == 5'd16) begin
                step <= '0;
            end else begin
                step <= step + 5'd1;
            end
        end
    end

    // Double-dabble add-3 correction on every BCD nibble.
    always_comb begin
        bcd_adj = conv_bcd;
        for (int i = 0; i < 10; i++) begin
            if (conv_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Snapshot the displayed value at the start of each refresh and convert it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_bin <= '0;
            conv_bcd <= '0;
            conv_cnt <= '0;
            show_neg <= 1'b0;
            show_err <= 1'b0;
        end else if (conv_start) begin
            conv_bin <= disp_val[31] ? 32'(32'sd0 - disp_val) : disp_val;
            conv_bcd <= '0;
            conv_cnt <= 6'd32;
            show_neg <= disp_val[31];
            show_err <= err;
        end else if (!conv_done) begin
            conv_bcd <= (bcd_adj << 1) | {39'd0, conv_bin[31]};
            conv_bin <= conv_bin << 1;
            conv_cnt <= conv_cnt - 6'd1;
        end
    end

    // Character for the current line position, counted from the right edge.
    always_comb begin
        ndisp = 4'd1;
        for (int i = 1; i < 10; i++) begin
            if (conv_bcd[4*i +: 4] != 4'd0) ndisp = 4'(i + 1);
        end
        char_pos = 4'(step - 5'd1);
        k        = 4'd15 - char_pos;
        digit_at = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k == 4'(i)) digit_at = conv_bcd[4*i +: 4];
        end
        ch = 8'h20;
        if (show_err) begin
            case (k)
                4'd0:    ch = 8'h72;
                4'd1:    ch = 8'h72;
                4'd2:    ch = 8'h45;
                default: ch = 8'h20;
            endcase
        end else if (k < ndisp) begin
            ch = 8'h30 + {4'd0, digit_at};
        end else if (k == ndisp && show_neg) begin
            ch = 8'h2D;
        end
    end

    // Byte and register-select for the write about to start.
    always_comb begin
        wr_rs   = 1'b0;
        wr_byte = 8'h80;
        if (lcd_state == L_PREP && init_phase) begin
            case (step[1:0])
                2'd0:    wr_byte = 8'h38;
                2'd1:    wr_byte = 8'h0C;
                2'd2:    wr_byte = 8'h06;
                default: wr_byte = 8'h01;
            endcase
        end else if (lcd_state == L_PREP) begin
            wr_rs   = 1'b1;
            wr_byte = ch;
        end
    end

    // LCD pins: registered so the bus never glitches around the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            lcd_e <= (lcd_next == L_PULSE);
            if (load_byte) begin
                lcd_rs   <= wr_rs;
                lcd_data <= wr_byte;
            end
        end
    end

endmodule

// File: tb/tb_calculator.sv
// Bench for calculator: table of key sequences with expected LCD line, LEDs
// and segment code, plus hand-written multi-cycle corner cases.
module tb_calculator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] swp = '0;
    logic [8:1] swd = '0;
    logic       lrd = 1'b0;
    logic [7:0] seg, led, lcd_data;
    logic       lcd_e, lcd_rs, lcd_rw;

    int total = 0;
    int bad   = 0;

    calculator #(.LCD_E_CYCLES(2), .LCD_WAIT_CYCLES(6), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .swp0(swp[0]), .swp1(swp[1]), .swp2(swp[2]), .swp3(swp[3]), .swp4(swp[4]),
        .swp5(swp[5]), .swp6(swp[6]), .swp7(swp[7]), .swp8(swp[8]), .swp9(swp[9]),
        .lrd(lrd), .swd1(swd[1]), .swd2(swd[2]), .swd3(swd[3]), .swd4(swd[4]),
        .swd5(swd[5]), .swd6(swd[6]), .swd7(swd[7]), .swd8(swd[8]),
        .seg(seg), .led(led), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    // LCD bus monitor: logs writes and rebuilds line 1.
    logic [8:0]   wr_log [8];
    int           wr_n = 0;
    int           pos = 16;
    int           pass_cnt = 0;
    logic         e_prev = 1'b0;
    logic [127:0] line_buf = '0;
    logic [127:0] last_line = '0;

    always @(negedge clk) begin
        if (!rst) begin
            wr_n   = 0;
            pos    = 16;
            e_prev = 1'b0;
        end else begin
            if (lcd_e && !e_prev) begin
                if (wr_n < 8) wr_log[wr_n] = {lcd_rs, lcd_data};
                wr_n++;
                if (!lcd_rs && lcd_data == 8'h80) begin
                    pos = 0;
                end else if (lcd_rs && pos < 16) begin
                    line_buf[8*(15-pos) +: 8] = lcd_data;
                    pos++;
                    if (pos == 16) begin
                        last_line = line_buf;
                        pass_cnt++;
                    end
                end
            end
            e_prev = lcd_e;
        end
    end

    function automatic logic [127:0] rj(input logic [127:0] s);
        logic [127:0] r;
        r = s;
        for (int i = 0; i < 16; i++) if (r[8*i +: 8] == 8'h00) r[8*i +: 8] = 8'h20;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [127:0] exp);
        total++;
        if (last_line !== exp) begin
            bad++;
            $display("FAIL %s: lcd \"%s\" want \"%s\"", name, last_line, exp);
        end
    endtask

    task automatic wait_passes(input int n);
        int start;
        int cyc;
        start = pass_cnt;
        cyc   = 0;
        while (pass_cnt < start + n && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        total++;
        if (pass_cnt < start + n) begin
            bad++;
            $display("FAIL lcd_timeout: passes %0d want %0d", pass_cnt - start, n);
        end
        #1;
    endtask

    task automatic set_key(input logic [7:0] c, input logic v);
        case (c)
            "0", "1", "2", "3", "4", "5", "6", "7", "8", "9": swp[c - 8'h30] = v;
            "n": swd[1] = v;
            "+": swd[2] = v;
            "-": swd[3] = v;
            "*": swd[4] = v;
            "/": swd[5] = v;
            "b": swd[6] = v;
            "A": swd[7] = v;
            "=": swd[8] = v;
            "c": lrd    = v;
            default: ;
        endcase
    endtask

    task automatic press(input logic [7:0] c, input int hold);
        @(posedge clk); #1;
        set_key(c, 1'b1);
        repeat (hold) @(posedge clk);
        #1;
        set_key(c, 1'b0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_init(input string tag);
        int cyc;
        cyc = 0;
        while (wr_n < 5 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk({tag, " init0"}, 32'(wr_log[0]), 32'h038);
        chk({tag, " init1"}, 32'(wr_log[1]), 32'h00C);
        chk({tag, " init2"}, 32'(wr_log[2]), 32'h006);
        chk({tag, " init3"}, 32'(wr_log[3]), 32'h001);
        chk({tag, " home"},  32'(wr_log[4]), 32'h080);
        wait_passes(2);
        chk_line({tag, " line0"}, rj("0"));
    endtask

    typedef struct {
        logic [255:0] keys;
        logic [127:0] line;
        logic [7:0]   led;
        logic [7:0]   seg;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [255:0] k, input logic [127:0] l,
                       input logic [7:0] ld, input logic [7:0] sg);
        vec_t v;
        v.keys = k;
        v.line = rj(l);
        v.led  = ld;
        v.seg  = sg;
        vq.push_back(v);
    endtask

    initial begin
        logic [7:0] c;
        int         cyc;

        add("A23-n456-234-234-234-234=", "-457",        8'h80, 8'h66);
        add("A12*3=",                    "36",          8'h00, 8'h4F);
        add("+4=",                       "40",          8'h00, 8'h66);
        add("A9/n2=",                    "-4",          8'h80, 8'h5B);
        add("A7n/2=",                    "-3",          8'h80, 8'h5B);
        add("A7/0=",                     "Err",         8'h40, 8'h3F);
        add("5",                         "Err",         8'h40, 8'h3F);
        add("A",                         "0",           8'h00, 8'h3F);
        add("A9999999999",               "999999999",   8'h20, 8'h6F);
        add("b",                         "99999999",    8'h20, 8'h6F);
        add("A5+3",                      "3",           8'h21, 8'h4F);
        add("n",                         "-3",          8'hA1, 8'hCF);
        add("=",                         "2",           8'h00, 8'h4F);
        add("*-",                        "2",           8'h02, 8'h4F);
        add("=",                         "2",           8'h00, 8'h4F);
        add("A99999*99999=",             "1409865409",  8'h00, 8'h6F);
        add("*2=",                       "-1475236478", 8'h80, 8'h5B);
        add("A65536*32768=",             "-2147483648", 8'h80, 8'h7F);
        add("/n1=",                      "-2147483648", 8'h80, 8'h06);
        add("A3+4=5=",                   "5",           8'h00, 8'h6D);
        add("A12+34c",                   "12",          8'h01, 8'h66);
        add("A1b",                       "0",           8'h20, 8'h06);

        // Reset state while held.
        #12;
        chk("rst led",      32'(led),      32'h00);
        chk("rst seg",      32'(seg),      32'h3F);
        chk("rst lcd_e",    32'(lcd_e),    32'h0);
        chk("rst lcd_rs",   32'(lcd_rs),   32'h0);
        chk("rst lcd_data", 32'(lcd_data), 32'h00);
        chk("lcd_rw",       32'(lcd_rw),   32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_init("boot");

        foreach (vq[i]) begin
            for (int b = 31; b >= 0; b--) begin
                c = vq[i].keys[8*b +: 8];
                if (c != 8'h00) press(c, 8);
            end
            chk($sformatf("v%0d led", i), 32'(led), 32'(vq[i].led));
            chk($sformatf("v%0d seg", i), 32'(seg), 32'(vq[i].seg));
            wait_passes(2);
            chk_line($sformatf("v%0d line", i), vq[i].line);
        end

        // Simultaneous digits: the lower digit wins.
        press("A", 8);
        press("1", 8);
        press("2", 8);
        @(posedge clk); #1;
        swp[5] = 1'b1; swp[8] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        swp[5] = 1'b0; swp[8] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("prio digit seg", 32'(seg), 32'h6D);
        // Add beats backspace in the same cycle.
        @(posedge clk); #1;
        swd[2] = 1'b1; swd[6] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        swd[2] = 1'b0; swd[6] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("prio op led", 32'(led), 32'h01);
        wait_passes(2);
        chk_line("prio line", rj("125"));

        // A key held for 100 cycles counts once.
        press("A", 8);
        press("1", 100);
        chk("hold led", 32'(led), 32'h20);
        wait_passes(2);
        chk_line("hold line", rj("1"));

        // Async reset in the middle of a data write.
        press("5", 8);
        press("n", 8);
        chk("pre-rst led", 32'(led), 32'hA0);
        chk("pre-rst seg", 32'(seg), 32'hED);
        cyc = 0;
        while (!(lcd_e && lcd_rs) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid-write strobe seen", 32'(lcd_e && lcd_rs), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("async lcd_e",    32'(lcd_e),    32'h0);
        chk("async lcd_rs",   32'(lcd_rs),   32'h0);
        chk("async lcd_data", 32'(lcd_data), 32'h00);
        chk("async led",      32'(led),      32'h00);
        chk("async seg",      32'(seg),      32'h3F);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_init("rerst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calculator.md
Name: calculator

Overview:
- Integer four-function calculator for the FPGA board.
- Takes 10 digit pushbuttons and 8 function DIP/push switches; accumulates chained operations left-to-right with no limit on chain length.
- Shows the current entry or result on a character LCD (HD44780-style, write-only), a 7-segment digit and status LEDs.
- Sits at board top level directly on switch and display pins.

Parameters:
- LCD_E_CYCLES, 50, clk cycles lcd_e is held high per write; also the setup and hold time around it.
- LCD_WAIT_CYCLES, 2000, idle cycles after each LCD command or data write.
- DEB_CYCLES, 16, stable cycles required per button (used only with DEBOUNCE_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- swp0..swp9  in  1 each  digit keys 0..9, active-high
- lrd  in  1  clear entry: current operand := 0, sign positive
- swd1  in  1  toggle sign of current entry
- swd2  in  1  add
- swd3  in  1  subtract
- swd4  in  1  multiply
- swd5  in  1  divide
- swd6  in  1  backspace: entry := entry/10, truncating
- swd7  in  1  all clear
- swd8  in  1  equals
- seg  out  8  7-segment code of last digit key; bits 0..6 = a..g active-high, bit7 = entry negative
- led  out  8  [0] add, [1] sub, [2] mul, [3] div pending (one-hot); [5] entry active; [6] error; [7] displayed value negative
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0
- lcd_data  out  8  LCD bus

Behaviour:
- Reset (rst=0, async): acc=0, entry=0, sign=+, pending op=none, error=0, seg=0x3F, led=0, lcd_e=0, lcd_rs=0, lcd_data=0x00. LCD sequencer returns to init.
- Inputs are synchronised with 2 flops. Each key acts once per rising edge; holding a key has no further effect. If several keys rise in the same cycle, only the lowest-priority-index key is taken: swd7 > lrd > swd8 > swd2..swd5 > swd1 > swd6 > digits (0..9 ascending).
- Digit d: entry := entry*10 + d (magnitude). Ignored once the entry has 9 digits. The first digit after equals starts a fresh calculation: acc cleared, op=none.
- Operand value = sign ? -entry : entry. Sign may be toggled before any digit is typed.
- Operator key (swd2..swd5):
  - If an entry is active: acc := acc OP operand, or acc := operand when op=none. Then op := key, entry cleared, sign cleared.
  - If no entry is active: only op is replaced.
- Equals: applies the pending op as above, op := none, displays acc. A following operator chains from acc.
- Arithmetic: 32-bit signed two's complement, results wrap. Division truncates toward zero.
- Divide by zero: error=1, acc unchanged, LCD shows "Err". Cleared only by swd7 or reset; every other key is ignored while error=1.
- Displayed value: the signed operand while an entry is active, otherwise acc.
- LCD:
  - Init sequence: 0x38, 0x0C, 0x06, 0x01.
  - Refresh loop: 0x80, then 16 data characters on line 1.
  - Line 1 content: value right-aligned in decimal with a leading '-' if negative, space padded.
  - Binary-to-decimal conversion is sequential, e.g. double-dabble. It must complete before each refresh begins.
  - Each write: lcd_rs and lcd_data set up, lcd_e high for LCD_E_CYCLES, low, then LCD_WAIT_CYCLES idle.
  - A value change mid-refresh is shown on the next pass.

Optional Feature:
- DEBOUNCE_EN defined: each synchronised button must be stable for DEB_CYCLES cycles before its edge is recognised.
- DEBOUNCE_EN undefined: edge detection is taken directly from the synchroniser output, with the same one-action-per-press rule.

Test Plan:
- Reset then idle: led=0, seg=0x3F, LCD init bytes 0x38, 0x0C, 0x06, 0x01 in order, then line 1 shows "0" right-aligned.
- Keys 2,3 sub, sign, 4,5,6, then "sub 234" four times, then equals: LCD shows "-457", led[7]=1, led[3:0]=0.
- Keys 1,2 mul 3 equals, then add 4 equals: 36, then 40.
- Keys 7 div 0 equals: led[6]=1, LCD "Err". Digit 5 is ignored. swd7 gives display "0" and led[6]=0.
- Keys 9 div sign 2 equals: -4 (truncation toward zero). Key 1 held for 100 cycles registers one digit only.
- Ten 9 keys entered: entry is 999999999 (the tenth is ignored). Backspace gives 99999999. Async rst pulsed mid-LCD-write: all outputs return to reset values immediately.
